// File: rtl/mult_datapath.sv
// Register/arithmetic datapath for the signed add-shift multiplier.
// Holds the sign bit X, the accumulator A and the multiplier/product-low register B.
module mult_datapath #(
    parameter int WIDTH = 8
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Reset_c,
    input  logic             Clr_Ld,
    input  logic             Add,
    input  logic             Fn,
    input  logic             Shift_En,
    input  logic [WIDTH-1:0] S,
    output logic             X,
    output logic [WIDTH-1:0] Aval,
    output logic [WIDTH-1:0] Bval,
    output logic             M
);

    logic             x_r;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic             x_s;
    logic [WIDTH-1:0] a_s;
    logic [WIDTH-1:0] b_s;
    logic [WIDTH:0]   sum_s;

    // Sign-extended add, or subtract by inverting S and injecting Fn as carry-in.
    function automatic logic [WIDTH:0] addsub(
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] s,
        input logic             fn
    );
        logic [WIDTH:0] s_ext;
        s_ext = {s[WIDTH-1], s} ^ {(WIDTH+1){fn}};
        return {a[WIDTH-1], a} + s_ext + {{WIDTH{1'b0}}, fn};
    endfunction

    // Next-state selection with fixed strobe priority.
    always_comb begin
        x_s   = x_r;
        a_s   = a_r;
        b_s   = b_r;
        sum_s = addsub(a_r, S, Fn);
        if (Reset_c) begin
            x_s = 1'b0;
            a_s = {WIDTH{1'b0}};
            b_s = {WIDTH{1'b0}};
        end else if (Clr_Ld) begin
            x_s = 1'b0;
            a_s = {WIDTH{1'b0}};
            b_s = S;
        end else if (Add) begin
            x_s = sum_s[WIDTH];
            a_s = sum_s[WIDTH-1:0];
        end else if (Shift_En) begin
            // X stays put so the product is sign-extended as it shifts down.
            a_s = {x_r, a_r[WIDTH-1:1]};
            b_s = {a_r[0], b_r[WIDTH-1:1]};
        end else begin
            x_s = x_r;
        end
    end

    // State registers with asynchronous clear.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            x_r <= 1'b0;
            a_r <= {WIDTH{1'b0}};
            b_r <= {WIDTH{1'b0}};
        end else begin
            x_r <= x_s;
            a_r <= a_s;
            b_r <= b_s;
        end
    end

    assign X    = x_r;
    assign Aval = a_r;
    assign Bval = b_r;
    assign M    = b_r[0];

endmodule
